handshake_responder: RTL and testbench

HANDSHAKE_RESPONDER -- requirements
Module: handshake_responder

---
 rtl/handshake_responder_pkg.sv | 27 ++
 rtl/handshake_responder_busy_counter.sv | 25 ++
 rtl/handshake_responder_checker.sv | 40 ++++
 rtl/handshake_responder.sv | 105 ++++++++++
 tb/tb_handshake_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/handshake_responder_pkg.sv
// Shared types and defaults for the handshake responder and its busy-phase counter.
package handshake_responder_pkg;

    localparam int unsigned BUSY_MIN_DEF = 2;
    localparam int unsigned BUSY_MAX_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp a requested busy length into the legal [lo, hi] window.
    function automatic logic [2:0] clamp_len(input logic [2:0] len,
                                             input int unsigned lo,
                                             input int unsigned hi);
        int unsigned v;
        v = {29'd0, len};
        if (v < lo) begin
            v = lo;
        end else if (v > hi) begin
            v = hi;
        end
        return v[2:0];
    endfunction

endpackage

// File: rtl/handshake_responder_busy_counter.sv
// Loadable down-counter; terminal count marks the last busy cycle.
module busy_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_en,
    output logic       o_tc
);

    logic [2:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_tc = (r_cnt == 3'd1);

endmodule

// File: rtl/handshake_responder_checker.sv
// Protocol checker for handshake_responder, attached with bind rather than embedded.
module handshake_responder_checker #(
    parameter int unsigned BUSY_MIN = 2,
    parameter int unsigned BUSY_MAX = 5
) (
    input logic clk,
    input logic reset,
    input logic start,
    input logic busy,
    input logic ready
);

    logic       r_busy_q;
    logic       r_start_idle_q;
    logic [3:0] r_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_q       <= 1'b0;
            r_start_idle_q <= 1'b0;
            r_run          <= '0;
        end else begin
            assert (!(busy && ready));
            assert (!r_start_idle_q || busy);
            // Falling busy: run length must be legal and ready must follow at once.
            if (r_busy_q && !busy) begin
                assert (ready);
                assert (({28'd0, r_run} >= BUSY_MIN) && ({28'd0, r_run} <= BUSY_MAX));
            end
            r_busy_q       <= busy;
            r_start_idle_q <= start && !busy && !ready;
            if (!busy) begin
                r_run <= '0;
            end else if (r_run != 4'hF) begin
                r_run <= r_run + 4'd1;
            end
        end
    end

endmodule

// File: rtl/handshake_responder.sv
// Request/response responder: accepts a start, stays busy for a clamped length,
// then pulses ready with req_data + length.
module handshake_responder
    import handshake_responder_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BUSY_MIN = BUSY_MIN_DEF,
    parameter int unsigned BUSY_MAX = BUSY_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        busy_len,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              overrun,
    output logic [7:0]        done_count
);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_tc;
    logic [2:0]        w_len;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_len;
    logic              r_busy;
    logic              r_ready;
    logic              r_overrun;
    logic [DATA_W-1:0] r_rsp;
    logic [7:0]        r_count;

    assign w_len = clamp_len(busy_len, BUSY_MIN, BUSY_MAX);

    busy_counter u_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_len),
        .i_en       (r_state == ST_BUSY),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next   = ST_BUSY;
                    w_accept = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_tc) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_len     <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_rsp     <= '0;
            r_count   <= '0;
        end else begin
            r_busy    <= (w_next == ST_BUSY);
            r_ready   <= (w_next == ST_DONE);
            r_overrun <= start && (r_state != ST_IDLE);
            if (w_accept) begin
                r_data <= req_data;
                r_len  <= w_len;
            end
            if ((r_state == ST_BUSY) && (w_next == ST_DONE)) begin
                r_rsp   <= r_data + DATA_W'(r_len);
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign busy       = r_busy;
    assign ready      = r_ready;
    assign overrun    = r_overrun;
    assign rsp_data   = r_rsp;
    assign done_count = r_count;

endmodule

// File: tb/tb_handshake_responder.sv
// Directed self-checking bench for handshake_responder.
module tb_handshake_responder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] req_data;
    logic [2:0] busy_len;
    logic       busy;
    logic       ready;
    logic [7:0] rsp_data;
    logic       overrun;
    logic [7:0] done_count;

    int n_tests;
    int n_fail;

    handshake_responder #(
        .DATA_W   (8),
        .BUSY_MIN (2),
        .BUSY_MAX (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req_data   (req_data),
        .busy_len   (busy_len),
        .busy       (busy),
        .ready      (ready),
        .rsp_data   (rsp_data),
        .overrun    (overrun),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and observe a fixed 10-cycle window afterwards.
    task automatic do_txn(input logic [7:0] data, input logic [2:0] len,
                          output int bcyc, output int nrdy, output int ncoinc,
                          output logic first_busy, output logic [7:0] rsp_at_rdy);
        start = 1'b1; req_data = data; busy_len = len;
        tick();
        start = 1'b0;
        first_busy = busy;
        bcyc = 0; nrdy = 0; ncoinc = 0; rsp_at_rdy = '0;
        for (int i = 0; i < 10; i++) begin
            if (busy && ready) ncoinc++;
            if (busy) bcyc++;
            if (ready) begin
                nrdy++;
                rsp_at_rdy = rsp_data;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        start = 1'b0; req_data = '0; busy_len = '0;
        reset = 1'b1;
        tick(); tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_tests++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp: got %h expected 00", rsp_data); end
        n_tests++; if (done_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", done_count); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int b, r, c; logic fb; logic [7:0] rs;
        do_txn(8'h10, 3'd3, b, r, c, fb, rs);
        n_tests++; if (fb !== 1'b1) begin n_fail++; $display("FAIL basic_first_busy: got %b expected 1", fb); end
        n_tests++; if (b != 3) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected 3", b); end
        n_tests++; if (r != 1) begin n_fail++; $display("FAIL basic_ready_pulses: got %0d expected 1", r); end
        n_tests++; if (rs !== 8'h13) begin n_fail++; $display("FAIL basic_rsp: got %h expected 13", rs); end
        n_tests++; if (rsp_data !== 8'h13) begin n_fail++; $display("FAIL basic_rsp_held: got %h expected 13", rsp_data); end
        n_tests++; if (done_count !== 8'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", done_count); end
        n_tests++; if (c != 0) begin n_fail++; $display("FAIL basic_coincide: got %0d expected 0", c); end
    endtask

    task automatic test_clamp;
        logic [7:0] d   [4] = '{8'h40, 8'h50, 8'h60, 8'h70};
        logic [2:0] l   [4] = '{3'd0, 3'd7, 3'd1, 3'd6};
        int         n   [4] = '{2, 5, 2, 5};
        logic [7:0] rsx [4] = '{8'h42, 8'h55, 8'h62, 8'h75};
        int b, r, c; logic fb; logic [7:0] rs;
        for (int i = 0; i < 4; i++) begin
            do_txn(d[i], l[i], b, r, c, fb, rs);
            n_tests++; if (b != n[i]) begin n_fail++; $display("FAIL clamp_busy_len[%0d]: got %0d expected %0d", i, b, n[i]); end
            n_tests++; if (r != 1) begin n_fail++; $display("FAIL clamp_ready[%0d]: got %0d expected 1", i, r); end
            n_tests++; if (rs !== rsx[i]) begin n_fail++; $display("FAIL clamp_rsp[%0d]: got %h expected %h", i, rs, rsx[i]); end
            n_tests++; if (done_count !== 8'(2 + i)) begin n_fail++; $display("FAIL clamp_count[%0d]: got %0d expected %0d", i, done_count, 2 + i); end
        end
    endtask

    task automatic test_wrap;
        int b, r, c; logic fb; logic [7:0] rs;
        do_txn(8'hFE, 3'd4, b, r, c, fb, rs);
        n_tests++; if (b != 4) begin n_fail++; $display("FAIL wrap_busy_len: got %0d expected 4", b); end
        n_tests++; if (rs !== 8'h02) begin n_fail++; $display("FAIL wrap_rsp: got %h expected 02", rs); end
        n_tests++; if (done_count !== 8'd6) begin n_fail++; $display("FAIL wrap_count: got %0d expected 6", done_count); end
    endtask

    task automatic test_overrun;
        int b, r, ov; logic [7:0] rs;
        b = 0; r = 0; ov = 0; rs = '0;
        start = 1'b1; req_data = 8'h20; busy_len = 3'd3;
        tick();
        start = 1'b0;
        if (busy) b++;
        if (overrun) ov++;
        tick();
        if (busy) b++;
        if (overrun) ov++;
        start = 1'b1; req_data = 8'h99; busy_len = 3'd7;
        tick();
        start = 1'b0;
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
        for (int i = 0; i < 10; i++) begin
            if (busy) b++;
            if (overrun) ov++;
            if (ready) begin
                r++;
                rs = rsp_data;
            end
            tick();
        end
        n_tests++; if (ov != 1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", ov); end
        n_tests++; if (b != 3) begin n_fail++; $display("FAIL overrun_busy_len: got %0d expected 3", b); end
        n_tests++; if (r != 1) begin n_fail++; $display("FAIL overrun_ready: got %0d expected 1", r); end
        n_tests++; if (rs !== 8'h23) begin n_fail++; $display("FAIL overrun_rsp: got %h expected 23", rs); end
        n_tests++; if (done_count !== 8'd7) begin n_fail++; $display("FAIL overrun_count_done: got %0d expected 7", done_count); end
    endtask

    task automatic test_reset_mid_busy;
        int b, r, c; logic fb; logic [7:0] rs;
        start = 1'b1; req_data = 8'h30; busy_len = 3'd4;
        tick();
        start = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", ready); end
        tick();
        reset = 1'b0;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready) r++;
            tick();
        end
        n_tests++; if (r != 0) begin n_fail++; $display("FAIL midrst_no_ready: got %0d expected 0", r); end
        n_tests++; if (done_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", done_count); end
        do_txn(8'h05, 3'd2, b, r, c, fb, rs);
        n_tests++; if (b != 2) begin n_fail++; $display("FAIL midrst_next_busy: got %0d expected 2", b); end
        n_tests++; if (rs !== 8'h07) begin n_fail++; $display("FAIL midrst_next_rsp: got %h expected 07", rs); end
        n_tests++; if (done_count !== 8'd1) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected 1", done_count); end
    endtask

    task automatic test_back_to_back;
        int r, c, ov;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r = 0; c = 0; ov = 0;
        start = 1'b1; req_data = 8'h00; busy_len = 3'd0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (busy && ready) c++;
            if (overrun) ov++;
            if (ready) r++;
            if (r == 256) break;
        end
        start = 1'b0;
        n_tests++; if (r != 256) begin n_fail++; $display("FAIL b2b_ready_count: got %0d expected 256", r); end
        n_tests++; if (done_count !== 8'd0) begin n_fail++; $display("FAIL b2b_count_wrap: got %0d expected 0", done_count); end
        n_tests++; if (c != 0) begin n_fail++; $display("FAIL b2b_coincide: got %0d expected 0", c); end
        n_tests++; if (ov != 767) begin n_fail++; $display("FAIL b2b_overruns: got %0d expected 767", ov); end
        n_tests++; if (rsp_data !== 8'h02) begin n_fail++; $display("FAIL b2b_rsp: got %h expected 02", rsp_data); end
        tick(); tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_clamp();
        test_wrap();
        test_overrun();
        test_reset_mid_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

bind handshake_responder handshake_responder_checker #(
    .BUSY_MIN (BUSY_MIN),
    .BUSY_MAX (BUSY_MAX)
) u_checker (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .ready (ready)
);
